// File: rtl/m_trap_ctrl_if.sv
// Bundle of exception, mret, flush handshake and CSR port signals of the machine-mode trap controller.
// slave is the trap controller itself; master is whoever drives its requests.
interface m_trap_ctrl_if;
    logic        exc_req_i;
    logic [3:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic [31:0] exc_tval_i;
    logic        mret_req_i;
    logic        flush_ack_i;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        flush_req_o;
    logic        trap_new_pc_req_o;
    logic [31:0] trap_new_pc_o;
    logic        trap_busy_o;
    logic        mie_o;

    modport slave (
        input  exc_req_i, exc_code_i, exc_pc_i, exc_tval_i, mret_req_i, flush_ack_i,
        input  csr_we_i, csr_addr_i, csr_wdata_i,
        output csr_rdata_o, flush_req_o, trap_new_pc_req_o, trap_new_pc_o, trap_busy_o, mie_o
    );

    modport master (
        output exc_req_i, exc_code_i, exc_pc_i, exc_tval_i, mret_req_i, flush_ack_i,
        output csr_we_i, csr_addr_i, csr_wdata_i,
        input  csr_rdata_o, flush_req_o, trap_new_pc_req_o, trap_new_pc_o, trap_busy_o, mie_o
    );
endinterface

// File: rtl/m_trap_ctrl.sv
// Machine-mode trap responder: takes exceptions and mret, owns mstatus/mtvec/mepc/mcause/mtval,
// and sequences flush -> one-cycle PC redirect.
module m_trap_ctrl #(
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
    parameter logic [3:0]  EXC_CODE_NONE = 4'd14
) (
    input logic            clk,
    input logic            rst,
    m_trap_ctrl_if.slave   bus
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        mie;
    logic        mpie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] target_ff;

    logic        exc_take;
    logic        ret_take;
    logic        wr_mstatus;
    logic        wr_mtvec;
    logic        wr_mepc;
    logic        wr_mcause;
    logic        wr_mtval;

    // Requests are only looked at in IDLE; an exception shadows a simultaneous mret.
    assign exc_take = (state == IDLE) && bus.exc_req_i && (bus.exc_code_i != EXC_CODE_NONE);
    assign ret_take = (state == IDLE) && bus.mret_req_i && !exc_take;

    assign wr_mstatus = bus.csr_we_i && (bus.csr_addr_i == ADDR_MSTATUS);
    assign wr_mtvec   = bus.csr_we_i && (bus.csr_addr_i == ADDR_MTVEC);
    assign wr_mepc    = bus.csr_we_i && (bus.csr_addr_i == ADDR_MEPC);
    assign wr_mcause  = bus.csr_we_i && (bus.csr_addr_i == ADDR_MCAUSE);
    assign wr_mtval   = bus.csr_we_i && (bus.csr_addr_i == ADDR_MTVAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (exc_take || ret_take) state_nxt = FLUSH;
            FLUSH:    if (bus.flush_ack_i) state_nxt = REDIRECT;
            REDIRECT: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.flush_req_o       = (state == FLUSH);
        bus.trap_new_pc_req_o = (state == REDIRECT);
        bus.trap_new_pc_o     = target_ff;
        bus.trap_busy_o       = (state != IDLE);
        bus.mie_o             = mie;
    end

    // CSR-port writes come first so a trap/mret commit to the same register overrides them.
    always_ff @(posedge clk) begin
        if (rst) begin
            mie       <= 1'b0;
            mpie      <= 1'b0;
            mtvec     <= MTVEC_RESET;
            mepc      <= 32'h0;
            mcause    <= 32'h0;
            mtval     <= 32'h0;
            target_ff <= 32'h0;
        end else begin
            if (wr_mstatus) begin
                mie  <= bus.csr_wdata_i[3];
                mpie <= bus.csr_wdata_i[7];
            end
            if (wr_mtvec) begin
                mtvec <= {bus.csr_wdata_i[31:2],
                          bus.csr_wdata_i[1] ? mtvec[1:0] : bus.csr_wdata_i[1:0]};
            end
            if (wr_mepc) begin
                mepc <= bus.csr_wdata_i & 32'hFFFF_FFFC;
            end
            if (wr_mcause) begin
                mcause <= bus.csr_wdata_i;
            end
            if (wr_mtval) begin
                mtval <= bus.csr_wdata_i;
            end

            if (exc_take) begin
                mepc      <= bus.exc_pc_i & 32'hFFFF_FFFC;
                mcause    <= {28'b0, bus.exc_code_i};
                mtval     <= bus.exc_tval_i;
                mpie      <= mie;
                mie       <= 1'b0;
                target_ff <= mtvec & 32'hFFFF_FFFC;
            end else if (ret_take) begin
                mie       <= mpie;
                mpie      <= 1'b1;
                target_ff <= mepc;
            end
        end
    end

    always_comb begin
        bus.csr_rdata_o = 32'h0;
        case (bus.csr_addr_i)
            ADDR_MSTATUS: bus.csr_rdata_o = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
            ADDR_MTVEC:   bus.csr_rdata_o = mtvec;
            ADDR_MEPC:    bus.csr_rdata_o = mepc;
            ADDR_MCAUSE:  bus.csr_rdata_o = mcause;
            ADDR_MTVAL:   bus.csr_rdata_o = mtval;
            default:      bus.csr_rdata_o = 32'h0;
        endcase
    end

endmodule

// File: doc/m_trap_ctrl.md
Name: m_trap_ctrl

Overview:
- Machine-mode trap responder; consumes exception requests (exc_req/exc_code) raised by the fetch-stage and later exception generators.
- On an accepted exception: commits mepc/mcause/mtval/mstatus, requests a pipeline flush, then issues a one-cycle PC redirect to the mtvec base.
- Also executes mret: restores the interrupt-enable state and redirects to mepc.
- Owns the trap CSRs and exposes a simple CSR read/write port to the CSR unit.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- EXC_CODE_NONE, 4'd14, sentinel exception code meaning "no exception"; a request carrying this code is ignored.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- exc_req_i  in  1  exception request from the exception generators
- exc_code_i  in  4  exception cause code (0 = instr misaligned, 12 = instr page fault, ...)
- exc_pc_i  in  32  PC of the faulting instruction
- exc_tval_i  in  32  trap value (faulting address); 0 when not applicable
- mret_req_i  in  1  mret retiring
- flush_ack_i  in  1  pipeline drained, from the forward/stall unit
- csr_we_i  in  1  CSR write strobe
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  32  CSR write data
- csr_rdata_o  out  32  CSR read data, combinational on csr_addr_i
- flush_req_o  out  1  pipeline flush request
- trap_new_pc_req_o  out  1  one-cycle redirect strobe
- trap_new_pc_o  out  32  redirect target, valid while trap_new_pc_req_o = 1
- trap_busy_o  out  1  high whenever the FSM is not IDLE
- mie_o  out  1  mstatus.MIE, to the interrupt logic

Behaviour:
- FSM states: IDLE, FLUSH, REDIRECT.
- IDLE -> FLUSH when the accept condition holds.
- FLUSH holds while flush_ack_i = 0; FLUSH -> REDIRECT on the first cycle flush_ack_i = 1.
- REDIRECT -> IDLE unconditionally after exactly one cycle.
- Accept condition, evaluated in IDLE only:
  - exc = exc_req_i & (exc_code_i != EXC_CODE_NONE).
  - ret = mret_req_i & ~exc; an exception has priority over a simultaneous mret, and that mret is dropped.
  - Requests arriving in FLUSH or REDIRECT are ignored; upstream must hold or replay them.
- Commit occurs in the accept cycle (registers update at that clock edge).
- Exception commit:
  - mepc <= {exc_pc_i[31:2], 2'b00}
  - mcause <= {28'b0, exc_code_i}; bit 31 = 0
  - mtval <= exc_tval_i
  - MPIE <= MIE; MIE <= 0
  - target_ff <= {mtvec[31:2], 2'b00}; vectored mode does not offset exceptions.
- mret commit:
  - MIE <= MPIE; MPIE <= 1
  - target_ff <= mepc
- Outputs per state:
  - flush_req_o = 1 in FLUSH only.
  - trap_new_pc_req_o = 1 in REDIRECT only.
  - trap_new_pc_o = target_ff.
  - trap_busy_o = (state != IDLE).
- Minimum latency, accept to redirect strobe: 2 cycles (flush_ack_i already high on entry to FLUSH).
- CSR map; unmapped addresses read 0 and ignore writes:
  - 0x300 mstatus: bit 3 MIE, bit 7 MPIE, bits 12:11 MPP hardwired 2'b11; all other bits read 0.
  - 0x305 mtvec: mode field [1:0] is WARL. Writes of 00 or 01 are taken; writes of 1x keep the previous mode. Base [31:2] is always written.
  - 0x341 mepc: bits [1:0] read 0.
  - 0x342 mcause: fully writable.
  - 0x343 mtval: fully writable.
- A CSR write in the same cycle as a commit to the same register: the trap/mret update wins and the CSR write is lost.
- A CSR write to a different register in that cycle proceeds normally.
- Reset:
  - state = IDLE
  - mstatus MIE = 0, MPIE = 0
  - mtvec = MTVEC_RESET
  - mepc, mcause, mtval, target_ff = 0
  - all outputs 0, except csr_rdata_o, which reflects the reset CSR values.
- Reset in FLUSH or REDIRECT aborts the sequence: no redirect strobe is issued, and CSRs return to reset values.

Test Plan:
1. mtvec = 0x8000_0100, MIE = 1; exc_req_i = 1, code 0, pc 0x8000_0042, tval 0x8000_0042; flush_ack_i high -> next cycle: mepc = 0x8000_0040, mcause = 0, mtval = 0x8000_0042, MIE = 0, MPIE = 1, flush_req_o = 1. One cycle later: trap_new_pc_req_o = 1 for 1 cycle with target 0x8000_0100.
2. Code 12 accepted, flush_ack_i held low 5 cycles -> flush_req_o high 5+1 cycles, trap_busy_o high throughout. A second exc_req_i during FLUSH is ignored: mcause stays 12.
3. exc_req_i with code 14 -> no state change, flush_req_o stays 0. exc_req_i (code 0) together with mret_req_i -> exception taken, mret dropped.
4. mepc = 0x8000_2000, MPIE = 1, MIE = 0; mret_req_i -> MIE = 1, MPIE = 1, redirect to 0x8000_2000.
5. CSR port: write mtvec 0x8000_0003 -> reads 0x8000_0001 when prior mode was 01 (reads 0x8000_0000 from reset mode 00). Write mepc 0xFFFF_FFFF -> reads 0xFFFF_FFFC. Read mstatus after reset -> 0x0000_1800. Write to mcause in the accept cycle -> trap value kept.
6. rst asserted in FLUSH -> next cycle state IDLE, all outputs 0, mepc = 0, mtvec = MTVEC_RESET. No trap_new_pc_req_o pulse occurs afterwards.
